multi_mem_bus: RTL and testbench

MULTI_MEM_BUS -- requirements
Module: multi_mem_bus

---
 rtl/multi_mem_bus.sv | 159 +++++++++++++++
 tb/tb_multi_mem_bus.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_mem_bus.sv
// multi_mem_bus: shared single-port memory serving NPORT cache ports.
//   One access is in flight at a time. Idle ports are arbitrated round-robin,
//   the winning request is latched, held for DELAY cycles, and then completed
//   with a one-cycle memEn strobe to the granted port.
//
// Ports:
//   clk            single clock, rising edge
//   reset          synchronous, active-high
//   rwFromCache    [2*NPORT]  per port: 00 idle, 01 read, 10 write, 11 idle
//   addrFromCache  [AW*NPORT] per-port address
//   dataFromCache  [DW*NPORT] per-port write data
//   dataToCache    [DW*NPORT] per-port registered read data
//   memEn          [NPORT]    per-port completion strobe (high during DONE)
//   Port i occupies bits [i*W +: W] of every flattened bus.
//
// Optional build macro MEMBUS_DEBUG_EN adds:
//   debugState [2] FSM state (IDLE=0, BUSY=1, DONE=2)
//   debugGrant [3] granted port index
//   debugDelay [8] current latency counter
module multi_mem_bus #(
    parameter int NPORT = 4,
    parameter int AW    = 8,
    parameter int DW    = 16,
    parameter int DELAY = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2*NPORT-1:0]    rwFromCache,
    input  logic [AW*NPORT-1:0]   addrFromCache,
    input  logic [DW*NPORT-1:0]   dataFromCache,
    output logic [DW*NPORT-1:0]   dataToCache,
    output logic [NPORT-1:0]      memEn
`ifdef MEMBUS_DEBUG_EN
    ,
    output logic [1:0]            debugState,
    output logic [2:0]            debugGrant,
    output logic [7:0]            debugDelay
`endif
);

    localparam int GW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [GW-1:0]   ptr;
    logic [GW-1:0]   grant;
    logic [7:0]      cnt;
    logic            lat_write;
    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_data;

    logic [1:0]      rw_port    [NPORT];
    logic [AW-1:0]   addr_port  [NPORT];
    logic [DW-1:0]   wdata_port [NPORT];
    logic [DW-1:0]   rdata_q    [NPORT];

    logic [DW-1:0]   mem [2**AW];

    logic            req_found;
    logic [GW-1:0]   req_sel;
    logic [GW-1:0]   ptr_next;
    int              arb_idx;
    logic            finish_now;
    logic            commit_write;

    for (genvar i = 0; i < NPORT; i++) begin : g_port
        assign rw_port[i]                 = rwFromCache[2*i +: 2];
        assign addr_port[i]               = addrFromCache[AW*i +: AW];
        assign wdata_port[i]              = dataFromCache[DW*i +: DW];
        assign dataToCache[DW*i +: DW]    = rdata_q[i];
        assign memEn[i]                   = (state == DONE) && (grant == GW'(i));
    end

    // Round-robin search: ptr, ptr+1, ... wrapping; first active port wins.
    always_comb begin
        req_found = 1'b0;
        req_sel   = '0;
        arb_idx   = 0;
        for (int k = 0; k < NPORT; k++) begin
            arb_idx = (int'(ptr) + k) % NPORT;
            if (!req_found && (rw_port[arb_idx] == 2'b01 || rw_port[arb_idx] == 2'b10)) begin
                req_found = 1'b1;
                req_sel   = GW'(arb_idx);
            end
        end
    end

    assign ptr_next     = GW'((int'(req_sel) + 1) % NPORT);
    assign finish_now   = (state == BUSY) && (cnt == 8'd0);
    // Reset wins at the edge, so an aborted write never reaches the array.
    assign commit_write = !reset && finish_now && lat_write;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req_found) state_n = BUSY;
            BUSY:    if (cnt == 8'd0) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            grant     <= '0;
            cnt       <= 8'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_data  <= '0;
            for (int i = 0; i < NPORT; i++) begin
                rdata_q[i] <= '0;
            end
        end else begin
            state <= state_n;
            case (state)
                IDLE: begin
                    if (req_found) begin
                        grant     <= req_sel;
                        ptr       <= ptr_next;
                        cnt       <= 8'(DELAY - 1);
                        lat_write <= (rw_port[req_sel] == 2'b10);
                        lat_addr  <= addr_port[req_sel];
                        lat_data  <= wdata_port[req_sel];
                    end
                end
                BUSY: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else if (!lat_write) begin
                        for (int i = 0; i < NPORT; i++) begin
                            if (grant == GW'(i)) rdata_q[i] <= mem[lat_addr];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Array has no reset: contents survive a reset.
    always_ff @(posedge clk) begin
        if (commit_write) mem[lat_addr] <= lat_data;
    end

`ifdef MEMBUS_DEBUG_EN
    assign debugState = state;
    assign debugGrant = 3'(grant);
    assign debugDelay = cnt;
`endif

endmodule

// File: tb/tb_multi_mem_bus.sv
module tb_multi_mem_bus;
    localparam int NPORT = 4;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int DELAY = 4;

    logic                clk;
    logic                reset;
    logic [2*NPORT-1:0]  rwFromCache;
    logic [AW*NPORT-1:0] addrFromCache;
    logic [DW*NPORT-1:0] dataFromCache;
    logic [DW*NPORT-1:0] dataToCache;
    logic [NPORT-1:0]    memEn;

    multi_mem_bus #(.NPORT(NPORT), .AW(AW), .DW(DW), .DELAY(DELAY)) dut (
        .clk           (clk),
        .reset         (reset),
        .rwFromCache   (rwFromCache),
        .addrFromCache (addrFromCache),
        .dataFromCache (dataFromCache),
        .dataToCache   (dataToCache),
        .memEn         (memEn)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level reference: timestamps of grant/completion, RR pointer,
    // memory image and per-port read data.
    int          m_edge = 0;
    logic [15:0] m_mem [256];
    logic [15:0] m_data [NPORT];
    int          m_ptr = 0;
    bit          m_pend = 0;
    int          m_done = 0;
    int          m_free = 0;
    int          m_port = 0;
    bit          m_wr = 0;
    logic [7:0]  m_addr = '0;
    logic [15:0] m_wd = '0;
    logic [3:0]  exp_en = '0;
    logic [63:0] exp_dtc = '0;

    task automatic drive(input int p, input logic [1:0] op, input logic [7:0] a, input logic [15:0] d);
        rwFromCache[2*p +: 2]    = op;
        addrFromCache[8*p +: 8]  = a;
        dataFromCache[16*p +: 16] = d;
    endtask

    task automatic idle_all();
        rwFromCache = '0;
    endtask

    // Advance one clock; update the reference model with the inputs seen at
    // the edge, then return at the following falling edge.
    task automatic step();
        int p;
        logic [1:0] op;
        bit found;
        @(posedge clk);
        m_edge++;
        exp_en = '0;
        if (reset) begin
            m_pend = 0;
            m_ptr  = 0;
            for (int i = 0; i < NPORT; i++) m_data[i] = '0;
            m_free = m_edge + 1;
        end else if (m_pend && m_edge == m_done) begin
            if (m_wr) m_mem[m_addr] = m_wd;
            else      m_data[m_port] = m_mem[m_addr];
            exp_en[m_port] = 1'b1;
            m_pend = 0;
            m_free = m_edge + 2;
        end else if (!m_pend && m_edge >= m_free) begin
            found = 0;
            for (int k = 0; k < NPORT; k++) begin
                p  = (m_ptr + k) % NPORT;
                op = rwFromCache[2*p +: 2];
                if (!found && (op == 2'b01 || op == 2'b10)) begin
                    found  = 1;
                    m_pend = 1;
                    m_port = p;
                    m_wr   = (op == 2'b10);
                    m_addr = addrFromCache[8*p +: 8];
                    m_wd   = dataFromCache[16*p +: 16];
                    m_done = m_edge + DELAY;
                    m_ptr  = (p + 1) % NPORT;
                end
            end
        end
        for (int i = 0; i < NPORT; i++) exp_dtc[16*i +: 16] = m_data[i];
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_all();
        addrFromCache = '0;
        dataFromCache = '0;
        step();
        step();
        n_cmp++;
        if (memEn !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_memEn got %h exp 0", memEn);
        end
        n_cmp++;
        if (dataToCache !== 64'h0) begin
            n_err++;
            $display("FAIL reset_data got %h exp 0", dataToCache);
        end
        reset = 1'b0;
    endtask

    task automatic test_fill();
        bit got;
        for (int a = 0; a < 16; a++) begin
            drive(a % NPORT, 2'b10, 8'(a), 16'($urandom));
            got = 0;
            for (int c = 0; c < 12 && !got; c++) begin
                step();
                n_cmp++;
                if (memEn !== exp_en || dataToCache !== exp_dtc) begin
                    n_err++;
                    $display("FAIL fill edge=%0d memEn=%h exp=%h data=%h exp=%h", m_edge, memEn, exp_en, dataToCache, exp_dtc);
                end
                if (memEn[a % NPORT]) got = 1;
            end
            n_cmp++;
            if (!got) begin
                n_err++;
                $display("FAIL fill_timeout addr=%0d no memEn, required within 12 cycles", a);
            end
            idle_all();
            step();
        end
    endtask

    task automatic test_write_read();
        bit got;
        int e0;
        drive(0, 2'b10, 8'd0, 16'd3);
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            step();
            if (memEn[0]) got = 1;
        end
        idle_all();
        step();
        drive(0, 2'b01, 8'd0, 16'd0);
        e0 = m_edge + 1;
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            step();
            n_cmp++;
            if (memEn !== exp_en || dataToCache !== exp_dtc) begin
                n_err++;
                $display("FAIL wr_rd edge=%0d memEn=%h exp=%h data=%h exp=%h", m_edge, memEn, exp_en, dataToCache, exp_dtc);
            end
            if (memEn[0]) got = 1;
        end
        n_cmp++;
        if (!got || (m_edge - e0) != DELAY) begin
            n_err++;
            $display("FAIL wr_rd_latency got %0d (seen=%0d) exp %0d", m_edge - e0, got, DELAY);
        end
        n_cmp++;
        if (dataToCache[15:0] !== 16'd3) begin
            n_err++;
            $display("FAIL wr_rd_data got %h exp 0003", dataToCache[15:0]);
        end
        idle_all();
        step();
    endtask

    task automatic test_round_robin();
        int obs_port [5];
        int obs_edge [5];
        int n_obs;
        int g;
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int p = 0; p < NPORT; p++) drive(p, 2'b01, 8'(p), 16'd0);
        g = m_edge + 1;
        n_obs = 0;
        for (int c = 0; c < 40 && n_obs < 5; c++) begin
            step();
            n_cmp++;
            if (memEn !== exp_en || dataToCache !== exp_dtc) begin
                n_err++;
                $display("FAIL rr edge=%0d memEn=%h exp=%h data=%h exp=%h", m_edge, memEn, exp_en, dataToCache, exp_dtc);
            end
            for (int p = 0; p < NPORT; p++) begin
                if (memEn[p] && n_obs < 5) begin
                    obs_port[n_obs] = p;
                    obs_edge[n_obs] = m_edge;
                    n_obs++;
                end
            end
        end
        idle_all();
        step();
        n_cmp++;
        if (n_obs != 5) begin
            n_err++;
            $display("FAIL rr_count got %0d completions exp 5", n_obs);
        end else begin
            n_cmp++;
            if (obs_edge[0] - g != DELAY) begin
                n_err++;
                $display("FAIL rr_first_latency got %0d exp %0d", obs_edge[0] - g, DELAY);
            end
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (obs_port[i] != exp_order[i]) begin
                    n_err++;
                    $display("FAIL rr_order slot %0d got port %0d exp %0d", i, obs_port[i], exp_order[i]);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (obs_edge[i] - obs_edge[i-1] != DELAY + 2) begin
                        n_err++;
                        $display("FAIL rr_spacing slot %0d got %0d exp %0d", i, obs_edge[i] - obs_edge[i-1], DELAY + 2);
                    end
                end
            end
        end
    endtask

    task automatic test_collision();
        int first;
        bit got;
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(1, 2'b10, 8'd0, 16'd4);
        drive(2, 2'b01, 8'd0, 16'd0);
        first = -1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            step();
            n_cmp++;
            if (memEn !== exp_en || dataToCache !== exp_dtc) begin
                n_err++;
                $display("FAIL coll edge=%0d memEn=%h exp=%h data=%h exp=%h", m_edge, memEn, exp_en, dataToCache, exp_dtc);
            end
            if (memEn[1]) begin
                if (first < 0) first = 1;
                drive(1, 2'b00, 8'd0, 16'd0);
            end
            if (memEn[2]) begin
                if (first < 0) first = 2;
                got = 1;
            end
        end
        n_cmp++;
        if (first != 1) begin
            n_err++;
            $display("FAIL coll_first got port %0d exp 1", first);
        end
        n_cmp++;
        if (!got || dataToCache[47:32] !== 16'd4) begin
            n_err++;
            $display("FAIL coll_read got %h (seen=%0d) exp 0004", dataToCache[47:32], got);
        end
        idle_all();
        step();
    endtask

    task automatic test_reset_abort();
        logic [15:0] saved;
        bit got;
        saved = m_mem[5];
        drive(3, 2'b10, 8'd5, 16'd9);
        step();
        idle_all();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            n_cmp++;
            if (memEn !== 4'b0000 || memEn !== exp_en) begin
                n_err++;
                $display("FAIL abort_no_memEn edge=%0d got %h exp 0", m_edge, memEn);
            end
        end
        drive(0, 2'b01, 8'd5, 16'd0);
        got = 0;
        for (int c = 0; c < 12 && !got; c++) begin
            step();
            if (memEn[0]) got = 1;
        end
        n_cmp++;
        if (!got || dataToCache[15:0] !== saved) begin
            n_err++;
            $display("FAIL abort_read got %h (seen=%0d) exp %h", dataToCache[15:0], got, saved);
        end
        idle_all();
        step();
    endtask

    task automatic test_drop();
        logic [15:0] saved;
        bit got;
        int e0;
        saved = m_mem[7];
        drive(2, 2'b01, 8'd7, 16'd0);
        e0 = m_edge + 1;
        step();
        idle_all();
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            step();
            n_cmp++;
            if (memEn !== exp_en || dataToCache !== exp_dtc) begin
                n_err++;
                $display("FAIL drop edge=%0d memEn=%h exp=%h data=%h exp=%h", m_edge, memEn, exp_en, dataToCache, exp_dtc);
            end
            if (memEn[2]) got = 1;
        end
        n_cmp++;
        if (!got || (m_edge - e0) != DELAY || dataToCache[47:32] !== saved) begin
            n_err++;
            $display("FAIL drop_complete seen=%0d latency=%0d exp %0d data=%h exp %h", got, m_edge - e0, DELAY, dataToCache[47:32], saved);
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            for (int p = 0; p < NPORT; p++) begin
                drive(p, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 15)), 16'($urandom));
            end
            step();
            n_cmp++;
            if (memEn !== exp_en || dataToCache !== exp_dtc) begin
                n_err++;
                $display("FAIL random edge=%0d memEn=%h exp=%h data=%h exp=%h", m_edge, memEn, exp_en, dataToCache, exp_dtc);
            end
        end
        reset = 1'b0;
        idle_all();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) m_mem[i] = '0;
        for (int i = 0; i < NPORT; i++) m_data[i] = '0;
        reset = 1'b1;
        rwFromCache = '0;
        addrFromCache = '0;
        dataFromCache = '0;
        test_reset();
        test_fill();
        test_write_read();
        test_round_robin();
        test_collision();
        test_reset_abort();
        test_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule
